// File: rtl/aes_block_loader_pkg.sv
// Shared types and sizing for the AES block loader.
// The key width follows the round count: 10/12/14 rounds -> 4/6/8 key words.
package aes_block_loader_pkg;
  localparam int NUM_ROUNDS        = 10;
  localparam int DEFAULT_KEY_WORDS = NUM_ROUNDS - 6;
  localparam int WORDS_PER_BLOCK   = 4;
  localparam int WORD_W            = 32;

  typedef logic [127:0]                  state_t;
  typedef logic [32*DEFAULT_KEY_WORDS-1:0] key_t;
endpackage

// File: rtl/aes_block_loader_if.sv
// Word-stream input and block-slot output of the AES block loader.
// The loader takes the slave view; the feeder/pipeline side takes the master view.
interface aes_block_loader_if
  import aes_block_loader_pkg::*;
#(
  parameter int KEY_WORDS = DEFAULT_KEY_WORDS,
  parameter int CNT_W     = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WORD_W-1:0]      in_data;
  logic                   in_is_key;
  logic                   out_valid;
  logic                   out_ready;
  state_t                 out_state;
  logic [32*KEY_WORDS-1:0] out_key;
  logic                   key_loaded;
  logic                   err;
  logic [CNT_W-1:0]       blocks_issued;

  modport slave (
    input  in_valid, in_data, in_is_key, out_ready,
    output in_ready, out_valid, out_state, out_key, key_loaded, err, blocks_issued
  );

  modport master (
    output in_valid, in_data, in_is_key, out_ready,
    input  in_ready, out_valid, out_state, out_key, key_loaded, err, blocks_issued
  );
endinterface

// File: rtl/aes_word_shift_reg.sv
// MSB-first shift register of WORDS 32-bit words; next_val is the content after this shift.
// Single cycle; done pulses with the shift that completes the group; no backpressure of its own.
module aes_word_shift_reg
  import aes_block_loader_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  shift,
  input  logic [WORD_W-1:0]     din,
  output logic [WORDS*32-1:0]   next_val,
  output logic                  done,
  output logic                  busy
);
  localparam int CW = $clog2(WORDS);

  logic [WORDS*32-1:0] shadow;
  logic [CW-1:0]       cnt;

  assign next_val = {shadow[WORDS*32-33:0], din};
  assign done     = shift && (cnt == CW'(WORDS-1));
  assign busy     = (cnt != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow <= '0;
      cnt    <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (shift) begin
      shadow <= next_val;
      cnt    <= done ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/aes_block_loader.sv
// Assembles key and 128-bit data blocks from a word stream into one registered output slot.
// Block valid one cycle after its 4th data word; input stalls while the slot is full and not draining.
module aes_block_loader
  import aes_block_loader_pkg::*;
#(
  parameter int KEY_WORDS = DEFAULT_KEY_WORDS,
  parameter int CNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  aes_block_loader_if.slave  bus
);
  localparam int KW = 32*KEY_WORDS;

  logic          in_ready;
  logic          key_acc, data_acc, data_ok;
  logic          key_clr, data_clr, err_d;
  logic          kdone, kbusy, ddone, dbusy;
  logic [KW-1:0] key_next, key_active, out_key_q;
  state_t        data_next, out_state_q;
  logic          out_valid_q, key_loaded_q, err_q, take;
  logic [CNT_W-1:0] cnt_q;

  assign in_ready = !reset && !(out_valid_q && !bus.out_ready);
  assign take     = out_valid_q && bus.out_ready;

  always_comb begin
    key_acc  = 1'b0;
    data_acc = 1'b0;
    data_ok  = 1'b0;
    key_clr  = 1'b0;
    data_clr = 1'b0;
    err_d    = 1'b0;
    if (bus.in_valid && in_ready) begin
      key_acc  = bus.in_is_key;
      data_acc = !bus.in_is_key;
    end
    // a word of the other kind abandons whatever partial group was in progress
    data_clr = key_acc && dbusy;
    key_clr  = data_acc && kbusy;
    data_ok  = data_acc && key_loaded_q;
    err_d    = data_clr || key_clr || (data_acc && !key_loaded_q);
  end

  aes_word_shift_reg #(.WORDS(KEY_WORDS)) u_key_sr (
    .clock    (clock),
    .reset    (reset),
    .clear    (key_clr),
    .shift    (key_acc),
    .din      (bus.in_data),
    .next_val (key_next),
    .done     (kdone),
    .busy     (kbusy)
  );

  aes_word_shift_reg #(.WORDS(WORDS_PER_BLOCK)) u_data_sr (
    .clock    (clock),
    .reset    (reset),
    .clear    (data_clr),
    .shift    (data_ok),
    .din      (bus.in_data),
    .next_val (data_next),
    .done     (ddone),
    .busy     (dbusy)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      key_active   <= '0;
      key_loaded_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_state_q  <= '0;
      out_key_q    <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      err_q <= err_d;
      if (kdone) begin
        key_active   <= key_next;
        key_loaded_q <= 1'b1;
      end
      // the slot captures its own key copy so later commits leave it alone
      if (ddone) begin
        out_state_q <= data_next;
        out_key_q   <= key_active;
        out_valid_q <= 1'b1;
      end else if (take) begin
        out_valid_q <= 1'b0;
      end
      if (take) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_state     = out_state_q;
  assign bus.out_key       = out_key_q;
  assign bus.key_loaded    = key_loaded_q;
  assign bus.err           = err_q;
  assign bus.blocks_issued = cnt_q;
endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
Upstream feeder for the AES encoder/decoder pipeline. Accepts a 32-bit word stream over a valid/ready handshake. Words are tagged as key or data. The block assembles a full cipher key and 128-bit data blocks, then presents each completed block, together with the key active at its completion, in one registered output slot under valid/ready. Its out_state/out_key drive the pipeline in/key inputs. At the encoder, out_ready is tied high.

Parameters:
KEY_WORDS, 4, number of 32-bit words per key (4/6/8 for AES-128/192/256); key_t width = 32*KEY_WORDS
CNT_W, 16, width of the issued-block counter

Ports:
clock  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  input word valid
in_ready  output  1  loader can accept a word this cycle
in_data  input  32  input word
in_is_key  input  1  1 = key word, 0 = data word
out_valid  output  1  out_state/out_key hold a complete block
out_ready  input  1  downstream accepts the block
out_state  output  state_t (128)  assembled data block
out_key  output  key_t  key bound to this block
key_loaded  output  1  a complete key has been committed since reset
err  output  1  one-cycle pulse on a protocol violation
blocks_issued  output  CNT_W  count of blocks accepted by downstream; wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Accept event: in_valid && in_ready. Words are accepted only on accept events.
- in_ready = !(out_valid && !out_ready), a combinational stall while the output slot is full and not draining. in_ready is forced 0 in any cycle where reset is high.
- Word order: the first word of a group fills the most-significant 32 bits (state[127:96]; key[32*KEY_WORDS-1 -: 32]). Later words fill successively lower slices.
- Key path:
  - Key words shift into key_shadow. kcnt counts 0..KEY_WORDS-1.
  - On the accepted word with kcnt==KEY_WORDS-1, key_active <= completed shadow and key_loaded <= 1, both the next cycle. kcnt wraps to 0.
  - Blocks already assembled or sitting in the output slot keep their own key copy and are unaffected by a key commit.
- Data path:
  - Data words shift into state_shadow. dcnt counts 0..3.
  - The 4th accepted data word loads the output slot at the next edge: out_state <= completed shadow, out_key <= key_active as it stands in that cycle, out_valid <= 1. dcnt wraps to 0.
- Output slot:
  - out_valid clears on out_valid && out_ready unless a new block loads in the same cycle. Back-to-back loading is allowed when out_ready=1, giving one block per 4 cycles at full rate.
  - blocks_issued increments on every out_valid && out_ready.
- Latency: 4th data word accepted at edge N -> out_valid=1 after edge N.
- Protocol errors (err=1 for exactly the next cycle, no sticky state):
  - Data word accepted while key_loaded==0: word dropped, dcnt unchanged.
  - Key word accepted while dcnt!=0: partial data block discarded (dcnt <= 0), then the key word is processed normally.
  - Data word accepted while kcnt!=0: partial key discarded (kcnt <= 0, key_active unchanged), then the data word is processed normally (still subject to the key_loaded rule).
- Reset values: out_valid=0, out_state=0, out_key=0, key_loaded=0, err=0, blocks_issued=0, kcnt=0, dcnt=0, shadows=0, key_active=0.
- Reset mid-operation: all partial key and data progress is discarded and a held output block is dropped. A key must be reloaded before data is accepted.
- Simultaneous events: a new block loads on the same edge the previous block is accepted -> out_valid stays 1 with the new content, and the counter increments once.

Decomposition:
- AESDefinitions package: state_t and key_t (existing); add WORDS_PER_BLOCK=4 and a localparam-derivable KEY_WORDS default per `NUM_ROUNDS configuration.
- One sub-module: aes_word_shift_reg #(WORDS). It is a 32-bit-in, WORDS*32-out MSB-first shift register with a count, done pulse, and clear. It is instantiated twice: for the key (KEY_WORDS) and for the data block (4).
- The FSM state is just kcnt, dcnt, and key_loaded; no separate state enum is needed.

Test Plan:
- Reset, then load key 000102030405060708090a0b0c0d0e0f (4 words) and data 00112233_44556677_8899aabb_ccddeeff -> out_valid one cycle after the 4th data word; out_state=00112233...ccddeeff; out_key=000102...0f; blocks_issued=1.
- Data word sent before any key -> err pulses 1 cycle, no out_valid, key_loaded=0.
- Hold out_ready=0 with one block in the slot, then stream a further 3 data words -> in_ready=0 while the slot is full and undrained; 1st block held unchanged; after out_ready=1 the 2nd block issues with the correct content.
- New key committed between two data blocks, while block 1 is still stalled in the slot -> block 1 keeps the old out_key; block 2 carries the new key.
- Key word injected after 2 data words -> err pulse, partial block discarded; the next 4 data words form a clean block.
- Assert reset after 3 data words -> all outputs return to reset values; a following data word produces err (key lost).
